// File: rtl/det_pkg.sv
// Shared definitions for the shared run-of-ones detector: FSM encodings and
// the width helper used for channel-index and run-counter sizing.
package det_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SCAN = 2'd1,
        ST_HOLD = 2'd2
    } state_t;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < v) r = i + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/controlador_detector_arbitro_rr.sv
// Combinational round-robin arbiter: grants the first requester found searching
// upward from ptr with wrap-around; returns a one-hot grant and its index.
module arbitro_rr
    import det_pkg::*;
#(
    parameter  int N_CANAIS = 4,
    localparam int CW       = clog2(N_CANAIS)
) (
    input  logic [N_CANAIS-1:0] req,
    input  logic [CW-1:0]       ptr,
    output logic [N_CANAIS-1:0] grant,
    output logic [CW-1:0]       idx,
    output logic                any
);

    int j;

    always_comb begin
        grant = '0;
        idx   = '0;
        any   = 1'b0;
        j     = 0;
        for (int i = 0; i < N_CANAIS; i++) begin
            j = (int'(ptr) + i) % N_CANAIS;
            if (!any && req[j]) begin
                any      = 1'b1;
                grant[j] = 1'b1;
                idx      = CW'(j);
            end
        end
    end

endmodule

// File: rtl/controlador_detector.sv
// One run-of-ones detector shared by N_CANAIS serial sources via a round-robin
// valid/ready arbiter. Optional DET_COUNT_EN adds a saturating handshake counter.
module controlador_detector
    import det_pkg::*;
#(
    parameter  int N_CANAIS = 4,
    parameter  int RUN_LEN  = 3,
    localparam int CW       = clog2(N_CANAIS),
    localparam int RW       = clog2(RUN_LEN + 1)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                enable,
    input  logic                clear,
    input  logic [N_CANAIS-1:0] bit_valid,
    input  logic [N_CANAIS-1:0] bit_data,
    output logic [N_CANAIS-1:0] bit_ready,
    output logic                det_valid,
    input  logic                det_ready,
    output logic [CW-1:0]       det_chan,
    output logic [N_CANAIS-1:0] run_hit
`ifdef DET_COUNT_EN
    ,
    output logic [7:0]          det_count
`endif
);

    state_t              state, state_nxt;
    logic [CW-1:0]       ptr;
    logic [RW-1:0]       run [N_CANAIS];
    logic [N_CANAIS-1:0] grant;
    logic [CW-1:0]       gidx;
    logic                gany;
    logic                xfer;
    logic                bit_in;
    logic                evt;

    function automatic logic [RW-1:0] sat_inc_run(input logic [RW-1:0] v);
        return (v == RW'(RUN_LEN)) ? v : v + 1'b1;
    endfunction

    arbitro_rr #(.N_CANAIS(N_CANAIS)) u_arb (
        .req   (bit_valid),
        .ptr   (ptr),
        .grant (grant),
        .idx   (gidx),
        .any   (gany)
    );

    assign bit_in = bit_data[gidx];
    // A 1 that lands on run >= RUN_LEN-1 reaches or keeps the saturated value.
    assign evt    = xfer && bit_in && (run[gidx] >= RW'(RUN_LEN - 1));

    always_comb begin
        state_nxt = state;
        bit_ready = '0;
        xfer      = 1'b0;
        case (state)
            ST_IDLE: begin
                if (enable) state_nxt = ST_SCAN;
            end
            ST_SCAN: begin
                if (!clear) begin
                    bit_ready = grant;
                    xfer      = gany;
                end
                if (evt)          state_nxt = ST_HOLD;
                else if (!enable) state_nxt = ST_IDLE;
            end
            ST_HOLD: begin
                if (det_ready) state_nxt = enable ? ST_SCAN : ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            ptr       <= '0;
            run_hit   <= '0;
            det_valid <= 1'b0;
            det_chan  <= '0;
            for (int c = 0; c < N_CANAIS; c++) run[c] <= '0;
        end else begin
            state <= state_nxt;
            if (clear) begin
                ptr     <= '0;
                run_hit <= '0;
                for (int c = 0; c < N_CANAIS; c++) run[c] <= '0;
            end else if (xfer) begin
                ptr <= (gidx == CW'(N_CANAIS - 1)) ? '0 : gidx + 1'b1;
                if (bit_in) begin
                    run[gidx]     <= sat_inc_run(run[gidx]);
                    run_hit[gidx] <= (run[gidx] >= RW'(RUN_LEN - 1));
                end else begin
                    run[gidx]     <= '0;
                    run_hit[gidx] <= 1'b0;
                end
            end
            // Event register holds until consumed; clear does not touch it.
            if (evt) begin
                det_valid <= 1'b1;
                det_chan  <= gidx;
            end else if (det_valid && det_ready) begin
                det_valid <= 1'b0;
            end
        end
    end

`ifdef DET_COUNT_EN
    function automatic logic [7:0] sat_inc_cnt(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    always_ff @(posedge clk) begin
        if (!rst_n || clear) begin
            det_count <= '0;
        end else if (det_valid && det_ready) begin
            det_count <= sat_inc_cnt(det_count);
        end
    end
`endif

endmodule

// File: tb/tb_controlador_detector.sv
// Directed scoreboard bench for controlador_detector (N_CANAIS=4, RUN_LEN=3).
module tb_controlador_detector;

    localparam int N  = 4;
    localparam int RL = 3;

    logic         clk = 1'b0;
    logic         rst_n, enable, clear, det_ready;
    logic [N-1:0] bit_valid, bit_data;
    logic [N-1:0] bit_ready, run_hit;
    logic         det_valid;
    logic [1:0]   det_chan;
`ifdef DET_COUNT_EN
    logic [7:0]   det_count;
`endif

    int n_checks = 0;
    int n_fail   = 0;
    int mrun[N];
    int q[$];
    int mcount = 0;

    controlador_detector #(.N_CANAIS(N), .RUN_LEN(RL)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .enable    (enable),
        .clear     (clear),
        .bit_valid (bit_valid),
        .bit_data  (bit_data),
        .bit_ready (bit_ready),
        .det_valid (det_valid),
        .det_ready (det_ready),
        .det_chan  (det_chan),
        .run_hit   (run_hit)
`ifdef DET_COUNT_EN
        ,
        .det_count (det_count)
`endif
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] hits();
        logic [31:0] h;
        h = '0;
        for (int i = 0; i < N; i++) h[i] = (mrun[i] == RL);
        return h;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic zero_model();
        for (int i = 0; i < N; i++) mrun[i] = 0;
    endtask

    // One clock cycle: drive inputs, check combinational grant and pending
    // event against the scoreboard, update model, advance, check run_hit.
    task automatic cyc(input logic [N-1:0] v, input logic [N-1:0] d,
                       input logic dr, input int g);
        logic [31:0] exp_grant;
        bit_valid = v;
        bit_data  = d;
        det_ready = dr;
        #1;
        exp_grant = (g < 0) ? 32'd0 : (32'd1 << g);
        check("bit_ready", {28'd0, bit_ready}, exp_grant);
        check("det_valid", {31'd0, det_valid}, {31'd0, q.size() != 0});
        if (q.size() != 0) check("det_chan", {30'd0, det_chan}, q[0]);
        if (dr && q.size() != 0) begin
            void'(q.pop_front());
            if (mcount < 255) mcount++;
        end
        if (g >= 0) begin
            if (d[g]) begin
                if (mrun[g] < RL) mrun[g]++;
                if (mrun[g] == RL) q.push_back(g);
            end else begin
                mrun[g] = 0;
            end
        end
        tick();
        check("run_hit", {28'd0, run_hit}, hits());
    endtask

    initial begin
        rst_n = 1'b0; enable = 1'b0; clear = 1'b0; det_ready = 1'b0;
        bit_valid = '0; bit_data = '0;
        zero_model();
        tick(); tick();
        check("rst_det_valid", {31'd0, det_valid}, 32'd0);
        check("rst_det_chan",  {30'd0, det_chan},  32'd0);
        check("rst_bit_ready", {28'd0, bit_ready}, 32'd0);
        check("rst_run_hit",   {28'd0, run_hit},   32'd0);
        rst_n  = 1'b1;
        enable = 1'b1;

        // Power-up: IDLE grants nothing, then channel 0 sends 1,1,1.
        cyc(4'b0001, 4'b0001, 0, -1);
        cyc(4'b0001, 4'b0001, 0, 0);
        cyc(4'b0001, 4'b0001, 0, 0);
        cyc(4'b0001, 4'b0001, 0, 0);
        cyc(4'b0001, 4'b0001, 0, -1);
        cyc(4'b0001, 4'b0001, 0, -1);
        cyc(4'b0001, 4'b0001, 1, -1);

        // Clear back to ptr=0, then channels 0 and 2 compete continuously.
        zero_model();
        clear = 1'b1;
        cyc(4'b0000, 4'b0000, 0, -1);
        clear = 1'b0;
        cyc(4'b0101, 4'b0101, 1, 0);
        cyc(4'b0101, 4'b0101, 1, 2);
        cyc(4'b0101, 4'b0101, 1, 0);
        cyc(4'b0101, 4'b0101, 1, 2);
        cyc(4'b0101, 4'b0101, 1, 0);
        cyc(4'b0101, 4'b0101, 1, -1);
        cyc(4'b0101, 4'b0101, 1, 2);
        cyc(4'b0101, 4'b0101, 1, -1);
        cyc(4'b0101, 4'b0101, 1, 0);
        cyc(4'b0101, 4'b0101, 1, -1);
        cyc(4'b0000, 4'b0000, 0, -1);

        // Channel 1: 1,1,0,1,1,1 then an overlapping extra 1.
        cyc(4'b0010, 4'b0010, 0, 1);
        cyc(4'b0010, 4'b0010, 0, 1);
        cyc(4'b0010, 4'b0000, 0, 1);
        cyc(4'b0010, 4'b0010, 0, 1);
        cyc(4'b0010, 4'b0010, 0, 1);
        cyc(4'b0010, 4'b0010, 0, 1);
        cyc(4'b0010, 4'b0010, 1, -1);
        cyc(4'b0010, 4'b0010, 0, 1);
        cyc(4'b0010, 4'b0010, 1, -1);
        cyc(4'b0000, 4'b0000, 0, -1);

        // Channel 3 reaches run=2, clear drops its offered bit and the run.
        cyc(4'b1000, 4'b1000, 0, 3);
        cyc(4'b1000, 4'b1000, 0, 3);
        zero_model();
        mcount = 0;
        clear = 1'b1;
        cyc(4'b1000, 4'b1000, 0, -1);
        clear = 1'b0;
`ifdef DET_COUNT_EN
        check("det_count_clear", {24'd0, det_count}, 32'd0);
`endif
        cyc(4'b1000, 4'b1000, 0, 3);
        cyc(4'b1000, 4'b1000, 0, 3);
        cyc(4'b1000, 4'b1000, 0, 3);

        // Consumer stalls five cycles in HOLD, then one handshake, then resume.
        for (int k = 0; k < 5; k++) cyc(4'b1000, 4'b1000, 0, -1);
        cyc(4'b1000, 4'b1000, 1, -1);
        cyc(4'b1000, 4'b1000, 0, 3);
`ifdef DET_COUNT_EN
        check("det_count", {24'd0, det_count}, mcount);
`endif

        // Reset while an event is pending discards it.
        check("pre_rst_det_valid", {31'd0, det_valid}, 32'd1);
        rst_n = 1'b0;
        tick();
        q.delete();
        zero_model();
        mcount = 0;
        check("midrst_det_valid", {31'd0, det_valid}, 32'd0);
        check("midrst_run_hit",   {28'd0, run_hit},   32'd0);
        check("midrst_bit_ready", {28'd0, bit_ready}, 32'd0);
        check("midrst_det_chan",  {30'd0, det_chan},  32'd0);
        rst_n = 1'b1;
        cyc(4'b0001, 4'b0001, 0, -1);
        cyc(4'b0001, 4'b0001, 0, 0);
        cyc(4'b0001, 4'b0001, 0, 0);
        cyc(4'b0001, 4'b0001, 0, 0);
        cyc(4'b0000, 4'b0000, 1, -1);
        cyc(4'b0000, 4'b0000, 0, -1);
`ifdef DET_COUNT_EN
        check("det_count_final", {24'd0, det_count}, mcount);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/controlador_detector.md
Name: controlador_detector

Overview:
- Shares one run-of-ones detector among N_CANAIS serial bit sources.
- A round-robin arbiter accepts at most one bit per cycle through a valid/ready handshake.
- A separate run counter is kept per channel, so each channel's run survives interleaving with other channels.
- When a channel's run of consecutive 1s reaches RUN_LEN, the block reports a detection event to a downstream consumer over a valid/ready handshake.

Parameters:
- N_CANAIS, 4, number of requesting serial channels (2..8).
- RUN_LEN, 3, consecutive accepted 1s per channel that constitute a detection (1..15).
- CW (localparam), clog2(N_CANAIS), channel index width.
- RW (localparam), clog2(RUN_LEN+1), run counter width.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  synchronous, active-low reset.
- enable  in  1  1 = arbitration allowed.
- clear  in  1  synchronous clear of all run counters and the priority pointer.
- bit_valid  in  N_CANAIS  per-channel bit offered.
- bit_data  in  N_CANAIS  per-channel serial bit.
- bit_ready  out  N_CANAIS  per-channel grant; at most one bit set (one-hot or zero).
- det_valid  out  1  detection event pending.
- det_ready  in  1  consumer accepts event.
- det_chan  out  CW  channel that produced the event.
- run_hit  out  N_CANAIS  level: run[c]==RUN_LEN (Moore view per channel).

Behaviour:
- Reset (rst_n=0 at a clk edge):
  - state=ST_IDLE; all run[c]=0; priority pointer ptr=0.
  - det_valid=0, det_chan=0, bit_ready=0, run_hit=0.
- FSM states:
  - ST_IDLE: bit_ready=0. If enable=1, go to ST_SCAN.
  - ST_SCAN: the arbiter grants the first requesting channel, searching from ptr upward with wrap-around. bit_ready is combinational from bit_valid, ptr and state.
    - If enable=0 and no event is generated this cycle, go to ST_IDLE.
  - ST_HOLD: bit_ready=0; det_valid=1. On det_ready=1, go to ST_SCAN if enable=1, else ST_IDLE. Grants resume the cycle after the handshake.
- Transfer: a bit transfers on channel c when bit_valid[c] & bit_ready[c]. Then ptr <= (c+1) mod N_CANAIS.
- Run update on a transferred bit b:
  - b=0: run[c] <= 0.
  - b=1: run[c] <= min(run[c]+1, RUN_LEN). The counter saturates and does not wrap.
- Event rule: a transferred 1 that makes or keeps run[c]==RUN_LEN is an event (overlapping detection).
  - Next cycle: det_valid=1, det_chan=c, state=ST_HOLD.
  - Latency from accepted bit to det_valid is 1 cycle.
  - Events are never dropped, because no further bits are accepted while det_valid=1.
- det_chan is stable while det_valid=1.
- run_hit is registered and updates in the same cycle as run[c].
- clear=1:
  - bit_ready forced 0 that cycle, so a bit offered that cycle does not transfer.
  - Next cycle: all run[c]=0 and ptr=0.
  - A pending event (det_valid, det_chan) is kept until handshaked.
- enable dropping during ST_HOLD: the event still completes, then the FSM goes to ST_IDLE.
- Run counters are retained across ST_IDLE.
- Reset asserted mid-run or mid-HOLD: all state returns to reset values at the next edge; the pending event is discarded.

Optional Feature:
- Macro: DET_COUNT_EN.
- Defined:
  - Adds output det_count [7:0], a saturating (stops at 255) count of completed det_valid&det_ready handshakes.
  - Zeroed by rst_n=0 or clear=1.
  - clear wins if it coincides with a handshake.
- Undefined: port absent; no counter logic.

Decomposition:
- Shared package/include det_pkg:
  - state encodings ST_IDLE=2'd0, ST_SCAN=2'd1, ST_HOLD=2'd2;
  - clog2 function used for CW/RW.
- One sub-module, arbitro_rr:
  - combinational round-robin grant from req[N_CANAIS] and ptr;
  - outputs a one-hot grant and the granted index.
- The FSM, run counters and event register stay in controlador_detector.

Test Plan:
- Reset, then enable=1; channel 0 offers 1,1,1 on consecutive cycles (others idle) -> third transfer gives det_valid=1, det_chan=0 next cycle; run_hit[0]=1; bit_ready=0 until det_ready.
- Channels 0 and 2 both hold bit_valid with data 1 continuously, det_ready=1 -> grants alternate 0,2,0,2,...; first event is det_chan=0 after its third accepted 1, then det_chan=2.
- Channel 1 sends 1,1,0,1,1,1 -> no event after the 0; exactly one event, after the final 1. A following extra 1 gives a second event (overlap, run saturates at 3).
- det_ready held 0 for 5 cycles during ST_HOLD -> det_valid and det_chan stable, bit_ready=0 throughout; a single handshake, then grants resume the next cycle.
- clear pulsed with run[3]=2 and channel 3 offering 1 -> that bit is not accepted; run[3]=0; two further 1s produce no event and a third does. With DET_COUNT_EN, det_count returns to 0.
- rst_n=0 asserted while det_valid=1 -> next cycle det_valid=0, run_hit=0, state ST_IDLE; a new sequence behaves as after power-up.
